// File: rtl/wb_daq_scheduler.sv
// DAQ channel scheduler: grants one of NUM_PORTS start_sram requesters access
// to the Wishbone bus master. It supports round-robin or fixed-priority
// selection, holds each grant until the master reports done, and aborts a
// stalled grant after TIMEOUT_CYCLES. A one-cycle RELEASE gap always separates
// two consecutive grants.
module wb_daq_scheduler #(
    parameter int NUM_PORTS      = 4,
    parameter int SEL_W          = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    input  logic [NUM_PORTS-1:0] request,
    input  logic [NUM_PORTS-1:0] enable_mask,
    input  logic                 fixed_priority,
    input  logic                 done,
    output logic [NUM_PORTS-1:0] grant,
    output logic [SEL_W-1:0]     select,
    output logic                 active,
    output logic                 timeout_err
);

    // The counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic             TO_EN    = (TIMEOUT_CYCLES > 0);
    // Reset pointer value makes port 0 the first port searched.
    localparam logic [SEL_W-1:0] PTR_RST  = SEL_W'(NUM_PORTS - 1);
    localparam logic [NUM_PORTS-1:0] ONE_HOT0 = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e               state_q,   state_d;
    logic [NUM_PORTS-1:0] grant_q,   grant_d;
    logic [SEL_W-1:0]     select_q,  select_d;
    logic                 active_q,  active_d;
    logic                 terr_q,    terr_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [SEL_W-1:0]     rr_ptr_q,  rr_ptr_d;

    logic [NUM_PORTS-1:0] eligible_s;
    logic                 pick_found_s;
    logic [SEL_W-1:0]     pick_idx_s;
    logic                 timeout_hit_s;

    assign eligible_s    = request & enable_mask;
    assign timeout_hit_s = TO_EN && (cnt_q == CNT_LAST);

    // Arbiter: choose the winning eligible port for the current mode.
    always_comb begin
        logic [SEL_W-1:0] idx_v;
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        idx_v        = '0;
        if (fixed_priority) begin
            // Scan downwards so the lowest eligible index is written last.
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                idx_v = SEL_W'(i);
                if (eligible_s[idx_v]) begin
                    pick_found_s = 1'b1;
                    pick_idx_s   = idx_v;
                end else begin
                    pick_found_s = pick_found_s;
                end
            end
        end else begin
            // Scan the rotated order backwards so the first port after the
            // last grant (smallest offset) wins.
            for (int off = NUM_PORTS; off >= 1; off--) begin
                idx_v = SEL_W'((int'(rr_ptr_q) + off) % NUM_PORTS);
                if (eligible_s[idx_v]) begin
                    pick_found_s = 1'b1;
                    pick_idx_s   = idx_v;
                end else begin
                    pick_found_s = pick_found_s;
                end
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/GRANT/RELEASE FSM.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        select_d = select_q;
        active_d = active_q;
        terr_d   = 1'b0;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    grant_d  = ONE_HOT0 << pick_idx_s;
                    select_d = pick_idx_s;
                    active_d = 1'b1;
                    rr_ptr_d = pick_idx_s;
                    cnt_d    = '0;
                    state_d  = ST_GRANT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (done) begin
                    // done takes precedence over a simultaneous timeout.
                    grant_d  = '0;
                    active_d = 1'b0;
                    state_d  = ST_RELEASE;
                end else if (timeout_hit_s) begin
                    grant_d  = '0;
                    active_d = 1'b0;
                    terr_d   = 1'b1;
                    state_d  = ST_RELEASE;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    state_d  = ST_GRANT;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                grant_d  = '0;
                active_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            select_q <= '0;
            active_q <= 1'b0;
            terr_q   <= 1'b0;
            cnt_q    <= '0;
            rr_ptr_q <= PTR_RST;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            select_q <= select_d;
            active_q <= active_d;
            terr_q   <= terr_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant       = grant_q;
    assign select      = select_q;
    assign active      = active_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_wb_daq_scheduler.sv
// Self-checking bench for wb_daq_scheduler: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a behavioural model of
// the scheduler's grant/release/timeout rules.
module tb_wb_daq_scheduler;

    localparam int NP = 4;
    localparam int SW = 2;
    localparam int TO = 8;

    logic          wb_clk = 1'b0;
    logic          wb_rst;
    logic [NP-1:0] request;
    logic [NP-1:0] enable_mask;
    logic          fixed_priority;
    logic          done;
    logic [NP-1:0] grant;
    logic [SW-1:0] select;
    logic          active;
    logic          timeout_err;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state: owner = granted port or -1.
    int m_owner;
    int m_age;
    int m_last;
    int m_sel;
    bit m_rel;
    bit m_terr;

    wb_daq_scheduler #(
        .NUM_PORTS(NP),
        .SEL_W(SW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .wb_clk(wb_clk),
        .wb_rst(wb_rst),
        .request(request),
        .enable_mask(enable_mask),
        .fixed_priority(fixed_priority),
        .done(done),
        .grant(grant),
        .select(select),
        .active(active),
        .timeout_err(timeout_err)
    );

    always #5 wb_clk = ~wb_clk;

    // Advance the model by one rising edge using the inputs present at it.
    task automatic model_edge();
        logic [NP-1:0] elig;
        int pick;
        if (wb_rst) begin
            m_owner = -1; m_age = 0; m_rel = 1'b0; m_terr = 1'b0;
            m_last = NP - 1; m_sel = 0;
        end else if (m_owner >= 0) begin
            m_terr = 1'b0;
            if (done) begin
                m_owner = -1; m_rel = 1'b1;
            end else if (m_age == TO - 1) begin
                m_owner = -1; m_rel = 1'b1; m_terr = 1'b1;
            end else begin
                m_age++;
            end
        end else if (m_rel) begin
            m_rel = 1'b0; m_terr = 1'b0;
        end else begin
            m_terr = 1'b0;
            elig = request & enable_mask;
            pick = -1;
            if (fixed_priority) begin
                for (int p = 0; p < NP; p++)
                    if (pick < 0 && elig[p]) pick = p;
            end else begin
                for (int k = 1; k <= NP; k++)
                    if (pick < 0 && elig[(m_last + k) % NP]) pick = (m_last + k) % NP;
            end
            if (pick >= 0) begin
                m_owner = pick; m_last = pick; m_sel = pick; m_age = 0;
            end
        end
    endtask

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [NP-1:0] eg;
        logic [SW-1:0] es;
        logic          ea;
        logic          et;
        eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        es = SW'(m_sel);
        ea = (m_owner >= 0);
        et = m_terr;
        n_vec++;
        assert (grant === eg) else begin
            n_err++; $error("FAIL %s grant observed=%b expected=%b", tag, grant, eg);
        end
        n_vec++;
        assert (select === es) else begin
            n_err++; $error("FAIL %s select observed=%0d expected=%0d", tag, select, es);
        end
        n_vec++;
        assert (active === ea) else begin
            n_err++; $error("FAIL %s active observed=%b expected=%b", tag, active, ea);
        end
        n_vec++;
        assert (timeout_err === et) else begin
            n_err++; $error("FAIL %s timeout_err observed=%b expected=%b", tag, timeout_err, et);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge wb_clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        wb_rst = 1'b1;
        done   = 1'b0;
        tick("reset");
        wb_rst = 1'b0;
    endtask

    initial begin
        int   seq[$];
        int   rr_exp[4] = '{1, 3, 1, 3};
        logic prev_act;
        int   cnt_a;
        int   cnt_t;
        int   bad;
        bit   reached;

        wb_rst = 1'b1; request = '0; enable_mask = '0;
        fixed_priority = 1'b0; done = 1'b0;
        m_owner = -1; m_age = 0; m_last = NP - 1; m_sel = 0;
        m_rel = 1'b0; m_terr = 1'b0;

        // Reset state.
        tick("reset");
        tick("reset");

        // Round-robin alternation between ports 1 and 3.
        enable_mask = 4'hF; request = 4'b1010; wb_rst = 1'b0;
        prev_act = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick("rr_alt");
            if (active === 1'b1 && prev_act !== 1'b1) seq.push_back(int'(select));
            prev_act = active;
            done = (m_owner >= 0 && m_age == 2);
        end
        check_val("rr_onsets", seq.size(), 4);
        for (int i = 0; i < 4; i++)
            check_val($sformatf("rr_sel%0d", i), (i < seq.size()) ? seq[i] : -1, rr_exp[i]);

        // Fixed priority starves ports 2 and 3.
        do_reset();
        fixed_priority = 1'b1; request = 4'b1110;
        prev_act = 1'b0; cnt_a = 0; bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick("fixed_prio");
            if (active === 1'b1 && prev_act !== 1'b1) begin
                cnt_a++;
                if (select !== 2'd1) bad++;
            end
            prev_act = active;
            done = (m_owner >= 0 && m_age == 1);
        end
        check_val("fp_onsets", cnt_a, 5);
        check_val("fp_starve", bad, 0);

        // Timeout on port 2 with done never asserted.
        do_reset();
        fixed_priority = 1'b0; request = 4'b0100;
        cnt_a = 0; cnt_t = 0;
        for (int c = 0; c < 25; c++) begin
            tick("timeout");
            if (c < 10 && grant === 4'b0100) cnt_a++;
            if (timeout_err === 1'b1) cnt_t++;
        end
        check_val("to_hold", cnt_a, 8);
        check_val("to_pulses", cnt_t, 2);

        // done coincides with timeout expiry: done wins.
        do_reset();
        request = 4'b0100; cnt_t = 0;
        for (int c = 0; c < 12; c++) begin
            tick("to_vs_done");
            if (timeout_err === 1'b1) cnt_t++;
            done = (m_owner >= 0 && m_age == TO - 1);
        end
        check_val("to_done_terr", cnt_t, 0);

        // Request and enable drop mid-grant: grant holds until done.
        do_reset();
        done = 1'b0; request = 4'b0001; enable_mask = 4'hF;
        tick("hold_start");
        request = 4'b0000; enable_mask = 4'h0;
        for (int c = 0; c < 4; c++) begin
            tick("hold_mid");
            check_val("hold_grant", int'(grant), 1);
        end
        done = 1'b1;
        tick("hold_done");
        done = 1'b0;
        cnt_a = 0;
        for (int c = 0; c < 6; c++) begin
            tick("hold_after");
            if (active !== 1'b0) cnt_a++;
        end
        check_val("hold_no_regrant", cnt_a, 0);

        // Reset asserted while port 3 holds the grant.
        do_reset();
        enable_mask = 4'hF; request = 4'b1111; reached = 1'b0;
        for (int c = 0; c < 30 && !reached; c++) begin
            tick("walk_to_p3");
            reached = (m_owner == 3);
            done = (m_owner >= 0 && !reached);
        end
        check_val("rst_p3_reached", int'(grant), 8);
        wb_rst = 1'b1; done = 1'b0;
        tick("rst_in_grant");
        check_val("rst_grant", int'(grant), 0);
        check_val("rst_active", int'(active), 0);
        check_val("rst_select", int'(select), 0);
        wb_rst = 1'b0;
        tick("post_rst");
        check_val("post_rst_port0", int'(grant), 1);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            wb_rst = ($urandom_range(0, 59) == 0);
            request = NP'($urandom);
            enable_mask = ($urandom_range(0, 9) == 0) ? 4'h0 : NP'($urandom);
            if ($urandom_range(0, 19) == 0) fixed_priority = ~fixed_priority;
            done = ($urandom_range(0, 4) == 0);
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
